// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_pkg
//  Description : Shared constants, types and pattern helpers for the traffic
//                light lamp guard.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] AMBER   = 2'b01;
    localparam logic [1:0] GREEN   = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    localparam int OFF_N = 0;
    localparam int OFF_E = 2;
    localparam int OFF_S = 4;
    localparam int OFF_W = 6;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_ILLEGAL  = 2'b01;
    localparam logic [1:0] FC_CONFLICT = 2'b10;
    localparam logic [1:0] FC_SKIP     = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_FLASH   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
    } lamps_t;

    localparam lamps_t LAMPS_ALL_RED = '{r: 4'hF, y: 4'h0, g: 4'h0};

    function automatic logic [1:0] approach(input logic [7:0] pat, input int off);
        return pat[off +: 2];
    endfunction

    function automatic lamps_t decode(input logic [7:0] pat);
        lamps_t     l;
        logic [1:0] code;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            code   = pat[2*i +: 2];
            l.r[i] = (code == RED);
            l.y[i] = (code == AMBER);
            l.g[i] = (code == GREEN);
        end
        return l;
    endfunction

    // Fault classification of a new pattern against the last legal one,
    // highest-priority fault wins.
    function automatic logic [1:0] check_pattern(input logic [7:0] prev, input logic [7:0] cur);
        logic       illegal;
        logic       skip;
        logic       ns_go;
        logic       ew_go;
        logic [1:0] c;
        logic [1:0] p;
        illegal = 1'b0;
        skip    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = cur[2*i +: 2];
            p = prev[2*i +: 2];
            if (c == ILLEGAL) illegal = 1'b1;
            if ((p == GREEN) && (c == RED)) skip = 1'b1;
        end
        ns_go = (approach(cur, OFF_N) != RED) || (approach(cur, OFF_S) != RED);
        ew_go = (approach(cur, OFF_E) != RED) || (approach(cur, OFF_W) != RED);
        if (illegal)             return FC_ILLEGAL;
        else if (ns_go && ew_go) return FC_CONFLICT;
        else if (skip)           return FC_SKIP;
        else                     return FC_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_stable_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_stable_filter
//  Description : Registers the light input and accepts it once it has been
//                stable for STABLE_CYC consecutive samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlc_stable_filter #(
    parameter int STABLE_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] light,
    output logic [7:0] cand,
    output logic [7:0] acc_pat,
    output logic       acc_stb
);
    localparam int              CW       = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]   c_stable = CW'(STABLE_CYC);

    logic [7:0]    cand_q, cand_d;
    logic [7:0]    pat_q, pat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stb_q, stb_d;

    always_comb begin
        cand_d = light;
        if (light != cand_q)
            cnt_d = CW'(1);
        else if (cnt_q == c_stable)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
        // Fire once per stable run; a saturated count only re-fires on a fresh run.
        stb_d = (cnt_d == c_stable) && ((light != cand_q) || (cnt_q != c_stable));
        pat_d = stb_d ? light : pat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= 8'h00;
            pat_q  <= 8'h00;
            cnt_q  <= '0;
            stb_q  <= 1'b0;
        end else begin
            cand_q <= cand_d;
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            stb_q  <= stb_d;
        end
    end

    assign cand    = cand_q;
    assign acc_pat = pat_q;
    assign acc_stb = stb_q;

endmodule
`default_nettype wire

// File: rtl/tlc_lamp_guard.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_lamp_guard
//  Description : Filters controller light patterns, blocks unsafe patterns and
//                falls back to amber flash until the controller shows all red.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlc_lamp_guard
    import tlc_pkg::*;
#(
    parameter int STABLE_CYC  = 3,
    parameter int FLASH_DIV   = 10,
    parameter int RECOVER_CYC = 20,
    parameter int INIT_CYC    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] light,
    output logic [3:0] lamp_r,
    output logic [3:0] lamp_y,
    output logic [3:0] lamp_g,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int IW = $clog2(INIT_CYC + 1);
    localparam int FW = $clog2(FLASH_DIV + 1);
    localparam int RW = $clog2(RECOVER_CYC + 1);

    localparam logic [IW-1:0] c_init_last  = IW'(INIT_CYC - 1);
    localparam logic [FW-1:0] c_flash_last = FW'(FLASH_DIV - 1);
    localparam logic [RW-1:0] c_recover    = RW'(RECOVER_CYC);

    logic [7:0] w_cand;
    logic [7:0] w_acc_pat;
    logic       w_acc_stb;
    logic [1:0] w_hit_code;
    logic       w_hit;
    logic [7:0] w_good_next;
    logic       w_enter_flash;

    state_t        state_q, state_d;
    lamps_t        lamps_q, lamps_d;
    logic          fault_q, fault_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    good_q, good_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_on_q, flash_on_d;
    logic [RW-1:0] rec_cnt_q, rec_cnt_d;

    tlc_stable_filter #(
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .light   (light),
        .cand    (w_cand),
        .acc_pat (w_acc_pat),
        .acc_stb (w_acc_stb)
    );

    assign w_hit_code  = w_acc_stb ? check_pattern(good_q, w_acc_pat) : FC_NONE;
    assign w_hit       = (w_hit_code != FC_NONE);
    assign w_good_next = (w_acc_stb && !w_hit) ? w_acc_pat : good_q;

    always_comb begin
        state_d       = state_q;
        lamps_d       = lamps_q;
        fault_d       = fault_q;
        code_d        = code_q;
        good_d        = good_q;
        init_cnt_d    = init_cnt_q;
        flash_cnt_d   = flash_cnt_q;
        flash_on_d    = flash_on_q;
        rec_cnt_d     = rec_cnt_q;
        w_enter_flash = 1'b0;

        case (state_q)
            ST_INIT: begin
                good_d = w_good_next;
                if (w_hit)
                    w_enter_flash = 1'b1;
                else if (init_cnt_q == c_init_last) begin
                    state_d = ST_NORMAL;
                    lamps_d = decode(w_good_next);
                end else
                    init_cnt_d = init_cnt_q + 1'b1;
            end
            ST_NORMAL: begin
                good_d = w_good_next;
                if (w_hit)
                    w_enter_flash = 1'b1;
                else
                    lamps_d = decode(w_good_next);
            end
            ST_FLASH: begin
                if (flash_cnt_q == c_flash_last) begin
                    flash_cnt_d = '0;
                    flash_on_d  = ~flash_on_q;
                end else
                    flash_cnt_d = flash_cnt_q + 1'b1;
                rec_cnt_d = (w_cand == 8'h00) ? rec_cnt_q + 1'b1 : '0;
                if (rec_cnt_d == c_recover) begin
                    state_d   = ST_RECOVER;
                    lamps_d   = LAMPS_ALL_RED;
                    fault_d   = 1'b0;
                    code_d    = FC_NONE;
                    good_d    = 8'h00;
                    rec_cnt_d = '0;
                end else begin
                    lamps_d.r = 4'h0;
                    lamps_d.y = {4{flash_on_d}};
                    lamps_d.g = 4'h0;
                end
            end
            ST_RECOVER: begin
                good_d = w_good_next;
                if (w_hit)
                    w_enter_flash = 1'b1;
                else begin
                    state_d = ST_NORMAL;
                    lamps_d = LAMPS_ALL_RED;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // The offending pattern never reaches the lamps: flash starts on the hit edge.
        if (w_enter_flash) begin
            state_d     = ST_FLASH;
            fault_d     = 1'b1;
            code_d      = w_hit_code;
            flash_cnt_d = '0;
            flash_on_d  = 1'b1;
            rec_cnt_d   = '0;
            lamps_d.r   = 4'h0;
            lamps_d.y   = 4'hF;
            lamps_d.g   = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            lamps_q     <= LAMPS_ALL_RED;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
            good_q      <= 8'h00;
            init_cnt_q  <= '0;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b0;
            rec_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lamps_q     <= lamps_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            good_q      <= good_d;
            init_cnt_q  <= init_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            rec_cnt_q   <= rec_cnt_d;
        end
    end

    assign lamp_r     = lamps_q.r;
    assign lamp_y     = lamps_q.y;
    assign lamp_g     = lamps_q.g;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
`default_nettype wire
